// File: rtl/io_bus_master_pkg.sv
// Shared constants, FSM state type and slave-select helper for the IO bus master.
package io_bus_master_pkg;

    localparam int CMD_ADDR_W = 32;
    localparam int IO_ADDR_W  = 28;
    localparam int IO_DATA_W  = 32;
    localparam int IO_SEL_W   = 16;
    localparam int CNT_W      = 16;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WRITE     = 3'd1,
        READ_WAIT = 3'd2,
        RESP      = 3'd3,
        GAP       = 3'd4
    } state_e;

    // Decode the slave index held in the top address nibble into a one-hot select.
    function automatic logic [IO_SEL_W-1:0] slave_onehot(input logic [3:0] idx);
        logic [IO_SEL_W-1:0] sel;
        sel      = '0;
        sel[idx] = 1'b1;
        return sel;
    endfunction

endpackage

// File: rtl/io_bus_master_if.sv
// Command/response handshake plus the slave-side IO bus, bundled for the master.
interface io_bus_master_if;

    logic                                     cmd_valid;
    logic                                     cmd_ready;
    logic                                     cmd_wr;
    logic [io_bus_master_pkg::CMD_ADDR_W-1:0] cmd_addr;
    logic [io_bus_master_pkg::IO_DATA_W-1:0]  cmd_wr_data;

    logic                                     rsp_valid;
    logic                                     rsp_ready;
    logic [io_bus_master_pkg::IO_DATA_W-1:0]  rsp_rd_data;
    logic                                     rsp_timeout;

    logic [io_bus_master_pkg::IO_SEL_W-1:0]   io_sel;
    logic                                     io_sync;
    logic [io_bus_master_pkg::IO_ADDR_W-1:0]  io_addr;
    logic                                     io_rd_en;
    logic                                     io_wr_en;
    logic [io_bus_master_pkg::IO_DATA_W-1:0]  io_wr_data;
    logic [io_bus_master_pkg::IO_DATA_W-1:0]  io_rd_data;
    logic                                     io_rd_ack;

    modport master (
        input  cmd_valid, cmd_wr, cmd_addr, cmd_wr_data, rsp_ready, io_rd_data, io_rd_ack,
        output cmd_ready, rsp_valid, rsp_rd_data, rsp_timeout,
        output io_sel, io_sync, io_addr, io_rd_en, io_wr_en, io_wr_data
    );

    modport slave (
        output cmd_valid, cmd_wr, cmd_addr, cmd_wr_data, rsp_ready, io_rd_data, io_rd_ack,
        input  cmd_ready, rsp_valid, rsp_rd_data, rsp_timeout,
        input  io_sel, io_sync, io_addr, io_rd_en, io_wr_en, io_wr_data
    );

endinterface

// File: rtl/io_master_timeout.sv
// Read-wait latency counter: cleared on load, counts enabled cycles, and flags
// the enabled cycle that would bring the count up to TIMEOUT_CYCLES.
module io_master_timeout
    import io_bus_master_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic io_clk,
    input  logic reset,
    input  logic load_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_q;

    // Count wait cycles; a fresh read always starts from zero.
    always_ff @(posedge io_clk) begin
        if (reset || load_i) begin
            count_q <= '0;
        end else if (enable_i) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    // Expiry is qualified by enable so an acknowledged cycle can never time out.
    assign expire_o = enable_i && (count_q == LAST_COUNT);

endmodule

// File: rtl/io_bus_master.sv
// Single-outstanding IO bus master: accepts a command, drives one write strobe
// or a held read strobe until ack/timeout, returns a response, then idles for
// IDLE_GAP cycles before taking the next command. All outputs are registered.
module io_bus_master
    import io_bus_master_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int IDLE_GAP       = 1
) (
    input  logic              io_clk,
    input  logic              reset,
    io_bus_master_if.master   bus,
    output logic [CNT_W-1:0]  timeout_count
);

    localparam logic [3:0] GAP_LAST = 4'(IDLE_GAP - 1);

    state_e                 state_q;
    logic                   cmd_ready_q;
    logic                   rsp_valid_q;
    logic                   rsp_timeout_q;
    logic [IO_DATA_W-1:0]   rsp_rd_data_q;
    logic [IO_SEL_W-1:0]    io_sel_q;
    logic                   io_sync_q;
    logic [IO_ADDR_W-1:0]   io_addr_q;
    logic                   io_rd_en_q;
    logic                   io_wr_en_q;
    logic [IO_DATA_W-1:0]   io_wr_data_q;
    logic [CNT_W-1:0]       timeout_count_q;
    logic [3:0]             gap_cnt_q;

    logic accept;
    logic tmr_load;
    logic tmr_enable;
    logic tmr_expire;

    assign accept     = (state_q == IDLE) && cmd_ready_q && bus.cmd_valid;
    assign tmr_load   = accept && !bus.cmd_wr;
    assign tmr_enable = (state_q == READ_WAIT) && !bus.io_rd_ack;

    io_master_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .io_clk   (io_clk),
        .reset    (reset),
        .load_i   (tmr_load),
        .enable_i (tmr_enable),
        .expire_o (tmr_expire)
    );

    // Transaction FSM with all bus and response outputs registered.
    always_ff @(posedge io_clk) begin
        if (reset) begin
            state_q         <= IDLE;
            cmd_ready_q     <= 1'b1;
            rsp_valid_q     <= 1'b0;
            rsp_timeout_q   <= 1'b0;
            rsp_rd_data_q   <= '0;
            io_sel_q        <= '0;
            io_sync_q       <= 1'b0;
            io_addr_q       <= '0;
            io_rd_en_q      <= 1'b0;
            io_wr_en_q      <= 1'b0;
            io_wr_data_q    <= '0;
            timeout_count_q <= '0;
            gap_cnt_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        io_addr_q    <= bus.cmd_addr[IO_ADDR_W-1:0];
                        io_wr_data_q <= bus.cmd_wr_data;
                        io_sel_q     <= slave_onehot(bus.cmd_addr[CMD_ADDR_W-1:IO_ADDR_W]);
                        io_sync_q    <= 1'b1;
                        io_wr_en_q   <= bus.cmd_wr;
                        io_rd_en_q   <= !bus.cmd_wr;
                        cmd_ready_q  <= 1'b0;
                        state_q      <= bus.cmd_wr ? WRITE : READ_WAIT;
                    end
                end

                WRITE: begin
                    io_sel_q      <= '0;
                    io_sync_q     <= 1'b0;
                    io_wr_en_q    <= 1'b0;
                    io_rd_en_q    <= 1'b0;
                    rsp_rd_data_q <= '0;
                    rsp_timeout_q <= 1'b0;
                    rsp_valid_q   <= 1'b1;
                    state_q       <= RESP;
                end

                READ_WAIT: begin
                    // Ack is tested first so data arriving on the last wait cycle wins.
                    if (bus.io_rd_ack) begin
                        io_sel_q      <= '0;
                        io_sync_q     <= 1'b0;
                        io_rd_en_q    <= 1'b0;
                        io_wr_en_q    <= 1'b0;
                        rsp_rd_data_q <= bus.io_rd_data;
                        rsp_timeout_q <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        state_q       <= RESP;
                    end else if (tmr_expire) begin
                        io_sel_q      <= '0;
                        io_sync_q     <= 1'b0;
                        io_rd_en_q    <= 1'b0;
                        io_wr_en_q    <= 1'b0;
                        rsp_rd_data_q <= '0;
                        rsp_timeout_q <= 1'b1;
                        rsp_valid_q   <= 1'b1;
                        if (timeout_count_q != '1) begin
                            timeout_count_q <= timeout_count_q + CNT_W'(1);
                        end
                        state_q       <= RESP;
                    end
                end

                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        gap_cnt_q   <= GAP_LAST;
                        state_q     <= GAP;
                    end
                end

                GAP: begin
                    if (gap_cnt_q == 4'd0) begin
                        cmd_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - 4'd1;
                    end
                end

                default: begin
                    io_sel_q    <= '0;
                    io_sync_q   <= 1'b0;
                    io_rd_en_q  <= 1'b0;
                    io_wr_en_q  <= 1'b0;
                    rsp_valid_q <= 1'b0;
                    cmd_ready_q <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rd_data = rsp_rd_data_q;
    assign bus.rsp_timeout = rsp_timeout_q;
    assign bus.io_sel      = io_sel_q;
    assign bus.io_sync     = io_sync_q;
    assign bus.io_addr     = io_addr_q;
    assign bus.io_rd_en    = io_rd_en_q;
    assign bus.io_wr_en    = io_wr_en_q;
    assign bus.io_wr_data  = io_wr_data_q;
    assign timeout_count   = timeout_count_q;

endmodule
